// File: rtl/usb_serial_line_echoer.sv
// usb_serial_line_echoer: case-toggling byte FIFO between usbSerial's host-to-device and device-to-host streams.
// Define USB_SERIAL_ECHO_LINE_MODE_EN to hold bytes until a CR/LF completes the line (line mode).
module usb_serial_line_echoer #(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk_48MHz,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [7:0]               o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(DEPTH):0]   o_fillLevel
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_ncommit;

    logic          w_push;
    logic          w_pop;
    logic          w_is_term;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_ncommit_next;

    // Letters flip case; everything else (including CR/LF) passes through.
    function automatic logic [7:0] f_toggle(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
        return b;
    endfunction

    assign o_in_ready  = (r_count != C_FULL);
    assign o_out_valid = (r_ncommit != '0);
    assign o_out_data  = o_out_valid ? r_mem[r_rptr] : 8'h00;
    assign o_fillLevel = r_count;

    assign w_push    = i_in_valid && o_in_ready;
    assign w_pop     = o_out_valid && i_out_ready;
    assign w_is_term = (i_in_data == 8'h0D) || (i_in_data == 8'h0A);

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

`ifdef USB_SERIAL_ECHO_LINE_MODE_EN
    // A full buffer without a terminator is released whole, otherwise input would stall forever.
    always_comb begin
        w_ncommit_next = r_ncommit;
        if (r_count == C_FULL)
            w_ncommit_next = w_count_next;
        else if (w_push && w_is_term)
            w_ncommit_next = w_count_next;
        else if (w_pop)
            w_ncommit_next = r_ncommit - C_CNT_ONE;
    end
`else
    always_comb begin
        w_ncommit_next = r_ncommit;
        case ({w_push, w_pop})
            2'b10:   w_ncommit_next = r_ncommit + C_CNT_ONE;
            2'b01:   w_ncommit_next = r_ncommit - C_CNT_ONE;
            default: w_ncommit_next = r_ncommit;
        endcase
    end
`endif

    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_ncommit <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + C_PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + C_PTR_ONE;
            r_count   <= w_count_next;
            r_ncommit <= w_ncommit_next;
        end
    end

    // NOTE: the storage array is not reset; clearing count/nCommit discards its contents and output data is gated to zero.
    always_ff @(posedge i_clk_48MHz) begin
        if (w_push)
            r_mem[r_wptr] <= f_toggle(i_in_data);
    end

endmodule

// File: tb/tb_usb_serial_line_echoer.sv
// Self-checking bench for usb_serial_line_echoer: directed steps plus random traffic against a queue model.
// Build with or without USB_SERIAL_ECHO_LINE_MODE_EN to exercise line or stream mode.
module tb_usb_serial_line_echoer;

    localparam int DEPTH = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] fill_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mq[$];
    int         m_commit = 0;
    logic [7:0] popped[$];

    usb_serial_line_echoer #(.DEPTH(DEPTH)) dut (
        .i_clk_48MHz (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_fillLevel (fill_level)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_xform(input logic [7:0] b);
        if (b >= "A" && b <= "Z") return b + 8'd32;
        if (b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    task automatic check_model();
        logic       e_valid;
        logic [7:0] e_data;
        e_valid = (m_commit != 0);
        e_data  = e_valid ? mq[0] : 8'h00;
        check("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
        check("out_valid",  32'(out_valid),  32'(e_valid));
        check("out_data",   32'(out_data),   32'(e_data));
        check("fill_level", 32'(fill_level), 32'(mq.size()));
    endtask

    // One clock: check outputs, drive inputs, advance the reference model at the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        bit m_push, m_pop, was_full;
        @(negedge clk);
        check_model();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        was_full  = (mq.size() == DEPTH);
        m_push    = v && !was_full;
        m_pop     = (m_commit != 0) && r;
        if (m_pop) popped.push_back(out_data);
        @(posedge clk);
        cyc++;
        if (m_pop) begin
            void'(mq.pop_front());
            m_commit--;
        end
        if (m_push) begin
            mq.push_back(m_xform(d));
`ifdef USB_SERIAL_ECHO_LINE_MODE_EN
            if (d == 8'h0D || d == 8'h0A) m_commit = mq.size();
`else
            m_commit++;
`endif
        end
`ifdef USB_SERIAL_ECHO_LINE_MODE_EN
        if (was_full) m_commit = mq.size();
`endif
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        mq.delete();
        m_commit = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_data",  32'(out_data),   32'h00);
        check("rst_fill",      32'(fill_level), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        do_reset();

`ifdef USB_SERIAL_ECHO_LINE_MODE_EN
        // Line held until CR, then released one byte per cycle.
        step(1'b1, "a", 1'b1);
        step(1'b1, "b", 1'b1);
        step(1'b1, "c", 1'b1);
        check("line_hold_valid", 32'(out_valid),  32'd0);
        check("line_hold_fill",  32'(fill_level), 32'd3);
        step(1'b1, 8'h0D, 1'b1);
        check("line_rel0", 32'(out_data), 32'h41);
        step(1'b0, 8'h00, 1'b1);
        check("line_rel1", 32'(out_data), 32'h42);
        step(1'b0, 8'h00, 1'b1);
        check("line_rel2", 32'(out_data), 32'h43);
        step(1'b0, 8'h00, 1'b1);
        check("line_rel3", 32'(out_data), 32'h0D);
        step(1'b0, 8'h00, 1'b1);
        check("line_empty", 32'(out_valid), 32'd0);

        // Overflow flush: a full unterminated buffer drains entirely.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h41 + i), 1'b1);
        check("ovf_fill",  32'(fill_level), 32'(DEPTH));
        check("ovf_valid", 32'(out_valid),  32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("ovf_rise", 32'(out_valid), 32'd1);
        check("ovf_data", 32'(out_data),  32'h61);
        popped.delete();
        repeat (DEPTH) step(1'b0, 8'h00, 1'b1);
        check("ovf_count", 32'(popped.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            check("ovf_order", 32'((i < popped.size()) ? popped[i] : 8'hFF), 32'(8'h61 + i));
        check("ovf_drained", 32'(fill_level), 32'd0);
`else
        // Stream: each byte appears one cycle after its push, case toggled.
        step(1'b1, 8'h61, 1'b1);
        check("stream0", 32'(out_data), 32'h41);
        step(1'b1, 8'h42, 1'b1);
        check("stream1", 32'(out_data), 32'h62);
        step(1'b1, 8'h33, 1'b1);
        check("stream2", 32'(out_data), 32'h33);
        step(1'b1, 8'h0A, 1'b1);
        check("stream3", 32'(out_data), 32'h0A);
        step(1'b0, 8'h00, 1'b1);
        check("stream_empty", 32'(out_valid), 32'd0);

        // Full with backpressure, then a single-cycle ready pulse.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h61 + i), 1'b0);
        check("full_ready", 32'(in_ready),   32'd0);
        check("full_fill",  32'(fill_level), 32'(DEPTH));
        step(1'b1, "z", 1'b0);
        check("stall_data0", 32'(out_data), 32'h41);
        step(1'b1, "z", 1'b0);
        check("stall_data1", 32'(out_data), 32'h41);
        step(1'b1, "z", 1'b1);
        check("pulse_ready", 32'(in_ready),   32'd1);
        check("pulse_fill",  32'(fill_level), 32'(DEPTH - 1));
        check("pulse_data",  32'(out_data),   32'h42);
        step(1'b1, "z", 1'b0);
        check("push17_fill", 32'(fill_level), 32'(DEPTH));
        check("push17_data", 32'(out_data),   32'h42);
        repeat (DEPTH) step(1'b0, 8'h00, 1'b1);
        check("full_drained", 32'(fill_level), 32'd0);
`endif

        // Reset mid-line discards everything immediately.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h6B + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_fill",  32'(fill_level), 32'd0);
        check("midrst_valid", 32'(out_valid),  32'd0);
        check("midrst_ready", 32'(in_ready),   32'd1);
        mq.delete();
        m_commit = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        popped.delete();
        step(1'b1, "x", 1'b1);
        step(1'b1, 8'h0D, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("midrst_count", 32'(popped.size()), 32'd2);
        check("midrst_b0", 32'((popped.size() > 0) ? popped[0] : 8'hFF), 32'h58);
        check("midrst_b1", 32'((popped.size() > 1) ? popped[1] : 8'hFF), 32'h0D);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                d = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            else
                d = 8'($urandom);
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0));
        end
        repeat (2 * DEPTH) step(1'b0, 8'h00, 1'b1);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
